// File: rtl/dropout_pkg.sv
// dropout_pkg: shared definitions for the dropout scheduler.
//   - scheduler FSM state encoding
//   - configuration register addresses and ctrl bit positions
//   - LFSR tap mask and default seed
package dropout_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GEN  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    localparam logic [1:0] CFG_RATE    = 2'd0;
    localparam logic [1:0] CFG_SEED_LO = 2'd1;
    localparam logic [1:0] CFG_SEED_HI = 2'd2;
    localparam logic [1:0] CFG_CTRL    = 2'd3;

    localparam int unsigned CTRL_ENABLE_BIT = 0;
    localparam int unsigned CTRL_CLEAR_BIT  = 1;

    localparam logic [15:0] LFSR_TAPS         = 16'hB400;
    localparam logic [15:0] LFSR_SEED_DEFAULT = 16'hACE1;

endpackage

// File: rtl/dropout_lfsr.sv
// dropout_lfsr: Galois right-shift LFSR with seed load.
//   clk, rst_n     : clock, asynchronous active-low reset (reset to SEED_DEFAULT)
//   i_load         : load i_load_val (an all-zero value loads SEED_DEFAULT)
//   i_load_val     : seed value
//   i_step         : advance one step
//   o_next_low     : low OUT_W bits of the value being registered this cycle
// A load beats a simultaneous step; the step is lost.
module dropout_lfsr
    import dropout_pkg::*;
#(
    parameter int unsigned       LFSR_W       = 16,
    parameter int unsigned       OUT_W        = 8,
    parameter logic [LFSR_W-1:0] SEED_DEFAULT = LFSR_W'(LFSR_SEED_DEFAULT)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_load,
    input  logic [LFSR_W-1:0] i_load_val,
    input  logic              i_step,
    output logic [OUT_W-1:0]  o_next_low
);

    logic [LFSR_W-1:0] r_lfsr;
    logic [LFSR_W-1:0] w_load_val;
    logic [LFSR_W-1:0] w_step_val;
    logic [LFSR_W-1:0] w_next;

    assign w_load_val = (i_load_val == '0) ? SEED_DEFAULT : i_load_val;
    assign w_step_val = (r_lfsr >> 1) ^ (r_lfsr[0] ? LFSR_W'(LFSR_TAPS) : '0);

    always_comb begin
        w_next = r_lfsr;
        if (i_load) begin
            w_next = w_load_val;
        end else if (i_step) begin
            w_next = w_step_val;
        end
    end

    assign o_next_low = w_next[OUT_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lfsr <= SEED_DEFAULT;
        end else begin
            r_lfsr <= w_next;
        end
    end

endmodule

// File: rtl/dropout_scheduler.sv
// dropout_scheduler: per-sample random bit dropout.
//   clk, rst_n           : clock, asynchronous active-low reset
//   cfg_we/addr/wdata    : config writes (0 rate, 1 seed_lo, 2 seed_hi+load, 3 ctrl)
//   in_valid/in_ready/in_data    : sample input, accepted only in IDLE
//   out_valid/out_ready/out_data : result (in_data & ~out_mask), held in HOLD
//   out_mask             : 1 = bit dropped
//   drop_cnt             : saturating count of dropped bits
//   busy                 : FSM not in IDLE
// Enabled samples spend DATA_W cycles in GEN (one mask bit per LFSR step);
// bypassed samples go straight to HOLD with a zero mask.
module dropout_scheduler
    import dropout_pkg::*;
#(
    parameter int unsigned       DATA_W       = 8,
    parameter int unsigned       LFSR_W       = 16,
    parameter logic [LFSR_W-1:0] SEED_DEFAULT = LFSR_W'(LFSR_SEED_DEFAULT)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_we,
    input  logic [1:0]        cfg_addr,
    input  logic [DATA_W-1:0] cfg_wdata,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [DATA_W-1:0] out_mask,
    output logic [7:0]        drop_cnt,
    output logic              busy
);

    localparam int unsigned CNT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int unsigned SEED_W = 2 * DATA_W;

    state_t r_state;
    state_t w_state_next;

    logic [DATA_W-1:0] r_rate;
    logic [DATA_W-1:0] r_seed_lo;
    logic              r_enable;
    logic [DATA_W-1:0] r_cap_data;
    logic [DATA_W-1:0] r_cap_rate;
    logic [DATA_W-1:0] r_mask;
    logic [CNT_W-1:0]  r_bit;
    logic [7:0]        r_drop_cnt;
    logic              r_live;

    logic              w_accept;
    logic              w_release;
    logic              w_gen;
    logic              w_last;
    logic              w_seed_load;
    logic              w_clear;
    logic              w_drop;
    logic [SEED_W-1:0] w_seed_cat;
    logic [DATA_W-1:0] w_next_low;

    assign w_accept    = in_valid & in_ready;
    assign w_release   = out_valid & out_ready;
    assign w_gen       = (r_state == ST_GEN);
    assign w_last      = (r_bit == CNT_W'(DATA_W - 1));
    assign w_seed_load = cfg_we && (cfg_addr == CFG_SEED_HI);
    assign w_clear     = cfg_we && (cfg_addr == CFG_CTRL) && cfg_wdata[CTRL_CLEAR_BIT];
    assign w_seed_cat  = {cfg_wdata, r_seed_lo};
    // During GEN the mask bit is judged on the value the LFSR is about to take,
    // which is the loaded seed when a seed write lands on the same cycle.
    assign w_drop      = w_gen && (w_next_low < r_cap_rate);

    dropout_lfsr #(
        .LFSR_W       (LFSR_W),
        .OUT_W        (DATA_W),
        .SEED_DEFAULT (SEED_DEFAULT)
    ) u_lfsr (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_seed_load),
        .i_load_val (LFSR_W'(w_seed_cat)),
        .i_step     (w_gen),
        .o_next_low (w_next_low)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        // r_live holds in_ready low until the first clock after reset release.
        in_ready     = (r_state == ST_IDLE) && r_live;
        out_valid    = (r_state == ST_HOLD);
        busy         = (r_state != ST_IDLE);
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_next = r_enable ? ST_GEN : ST_HOLD;
                end
            end
            ST_GEN: begin
                if (w_last) begin
                    w_state_next = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (w_release) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rate     <= '0;
            r_seed_lo  <= '0;
            r_enable   <= 1'b1;
            r_cap_data <= '0;
            r_cap_rate <= '0;
            r_mask     <= '0;
            r_bit      <= '0;
            r_live     <= 1'b0;
        end else begin
            r_live <= 1'b1;
            if (cfg_we) begin
                case (cfg_addr)
                    CFG_RATE:    r_rate    <= cfg_wdata;
                    CFG_SEED_LO: r_seed_lo <= cfg_wdata;
                    CFG_CTRL:    r_enable  <= cfg_wdata[CTRL_ENABLE_BIT];
                    default:     ;
                endcase
            end
            if (w_accept) begin
                r_cap_data <= in_data;
                r_cap_rate <= r_rate;
                r_mask     <= '0;
                r_bit      <= '0;
            end
            if (w_gen) begin
                r_bit <= r_bit + CNT_W'(1);
                if (w_drop) begin
                    r_mask[r_bit] <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_drop_cnt <= '0;
        end else if (w_clear) begin
            r_drop_cnt <= '0;
        end else if (w_drop && (r_drop_cnt != '1)) begin
            r_drop_cnt <= r_drop_cnt + 8'd1;
        end
    end

    assign out_data = r_cap_data & ~r_mask;
    assign out_mask = r_mask;
    assign drop_cnt = r_drop_cnt;

endmodule
